// File: rtl/watch_countdown_timer_pkg.sv
// watch_pkg: shared state encoding and BCD digit limits for the watch timer blocks
package watch_pkg;
  typedef enum logic [1:0] {TMR_IDLE, TMR_RUN, TMR_PAUSED, TMR_EXPIRED} tmr_state_e;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_MAX = 4'd9;
  localparam int HOUR_MAX = 12;
endpackage

// File: rtl/watch_countdown_timer_if.sv
// watch_countdown_timer_if: control/preset inputs and BCD/status outputs of the countdown timer
//   master drives tick/load/preset_*/start_resume/stop and reads hh/mm/ss/running/expired/done/load_err
//   slave is the timer side
interface watch_countdown_timer_if;
  logic tick, load, start_resume, stop;
  logic [7:0] preset_h, preset_m, preset_s;
  logic [7:0] hh, mm, ss;
  logic running, expired, done, load_err;
  modport master (output tick, load, preset_h, preset_m, preset_s, start_resume, stop,
                  input hh, mm, ss, running, expired, done, load_err);
  modport slave (input tick, load, preset_h, preset_m, preset_s, start_resume, stop,
                 output hh, mm, ss, running, expired, done, load_err);
endinterface

// File: rtl/watch_countdown_timer_bcd_down_digit.sv
// bcd_down_digit: one BCD digit that loads a value and counts down, wrapping 0 -> MAX
//   clk, reset (sync, active-high), load/load_val, dec_en in; digit, borrow_out out
module bcd_down_digit import watch_pkg::*; #(
  parameter logic [BCD_W-1:0] MAX = DIGIT_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec_en,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);
  always_ff @(posedge clk)
    digit <= reset ? '0 : load ? load_val : dec_en ? (digit == '0 ? MAX : digit - 1'b1) : digit;
  assign borrow_out = dec_en && digit == '0;
endmodule

// File: rtl/watch_countdown_timer.sv
// watch_countdown_timer: BCD HH:MM:SS countdown with load validation, pause/resume and expiry
//   clk, reset (sync, active-high); bus (slave) carries tick/load/presets/start_resume/stop in,
//   hh/mm/ss BCD, running, expired, done pulse, load_err pulse out
module watch_countdown_timer #(
  parameter int HOUR_MAX = watch_pkg::HOUR_MAX
) (
  input logic                  clk,
  input logic                  reset,
  watch_countdown_timer_if.slave bus
);
  import watch_pkg::*;
  tmr_state_e r_state, w_next;
  logic [7:0] r_hh, w_hval;
  logic r_done, r_load_err;
  logic w_valid, w_load_ok, w_dec, w_hdec, w_zero, w_one;
  logic w_b0, w_b1, w_b2, w_b3;
  logic [BCD_W-1:0] w_s0, w_s1, w_m0, w_m1;
  assign w_hval = 8'(bus.preset_h[7:4]) * 8'd10 + 8'(bus.preset_h[3:0]);
  assign w_valid = bus.preset_h[3:0] <= DIGIT_MAX && w_hval <= 8'(HOUR_MAX) &&
                   bus.preset_m[7:4] <= SEC_TENS_MAX && bus.preset_m[3:0] <= DIGIT_MAX &&
                   bus.preset_s[7:4] <= SEC_TENS_MAX && bus.preset_s[3:0] <= DIGIT_MAX;
  assign w_load_ok = bus.load && w_valid;
  // any load (even a rejected one) or stop consumes the tick of that cycle
  assign w_dec = r_state == TMR_RUN && bus.tick && !bus.load && !bus.stop;
  bcd_down_digit #(.MAX(DIGIT_MAX)) u_s0 (.clk, .reset, .load(w_load_ok), .load_val(bus.preset_s[3:0]),
    .dec_en(w_dec), .digit(w_s0), .borrow_out(w_b0));
  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_s1 (.clk, .reset, .load(w_load_ok), .load_val(bus.preset_s[7:4]),
    .dec_en(w_b0), .digit(w_s1), .borrow_out(w_b1));
  bcd_down_digit #(.MAX(DIGIT_MAX)) u_m0 (.clk, .reset, .load(w_load_ok), .load_val(bus.preset_m[3:0]),
    .dec_en(w_b1), .digit(w_m0), .borrow_out(w_b2));
  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_m1 (.clk, .reset, .load(w_load_ok), .load_val(bus.preset_m[7:4]),
    .dec_en(w_b2), .digit(w_m1), .borrow_out(w_b3));
  assign w_hdec = w_b3 && r_hh != 8'd0;
  assign w_zero = {r_hh, w_m1, w_m0, w_s1, w_s0} == 24'd0;
  // a decrement from exactly one second left is the one that lands on zero
  assign w_one = {r_hh, w_m1, w_m0, w_s1, w_s0} == 24'd1;
  always_comb begin
    w_next = w_load_ok ? TMR_IDLE :
             bus.load ? r_state :
             (bus.stop && r_state == TMR_RUN) ? TMR_PAUSED :
             (bus.start_resume && (r_state == TMR_IDLE || r_state == TMR_PAUSED) && !w_zero) ? TMR_RUN :
             (w_dec && w_one) ? TMR_EXPIRED : r_state;
  end
  always_ff @(posedge clk) begin
    r_state <= reset ? TMR_IDLE : w_next;
    r_done <= !reset && w_dec && w_one;
    r_load_err <= !reset && bus.load && !w_valid;
    r_hh <= reset ? 8'd0 : w_load_ok ? bus.preset_h :
            w_hdec ? (r_hh[3:0] == 4'd0 ? {r_hh[7:4] - 4'd1, DIGIT_MAX} : {r_hh[7:4], r_hh[3:0] - 4'd1}) : r_hh;
  end
  assign bus.hh = r_hh;
  assign bus.mm = {w_m1, w_m0};
  assign bus.ss = {w_s1, w_s0};
  assign bus.running = r_state == TMR_RUN;
  assign bus.expired = r_state == TMR_EXPIRED;
  assign bus.done = r_done;
  assign bus.load_err = r_load_err;
endmodule

// File: tb/tb_watch_countdown_timer.sv
// tb_watch_countdown_timer: directed + random stimulus checked against a seconds-count reference model
module tb_watch_countdown_timer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  watch_countdown_timer_if bus();
  watch_countdown_timer #(.HOUR_MAX(12)) dut (.clk(clk), .reset(reset), .bus(bus));
  localparam int IDLE = 0, RUN = 1, PAUSED = 2, EXP = 3;
  int n_vec = 0, n_err = 0;
  int m_rem = 0, m_st = IDLE;
  bit m_done = 0, m_err = 0;
  function automatic logic [7:0] bcd(int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction
  task automatic chk(string tag, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask
  task automatic step(bit rs, bit ld, logic [7:0] ph, logic [7:0] pm, logic [7:0] ps, bit st, bit sp, bit tk);
    int ht, ho, mt, mo, st_, so;
    bit ok;
    reset = rs; bus.load = ld; bus.preset_h = ph; bus.preset_m = pm; bus.preset_s = ps;
    bus.start_resume = st; bus.stop = sp; bus.tick = tk;
    ht = int'(ph[7:4]); ho = int'(ph[3:0]); mt = int'(pm[7:4]); mo = int'(pm[3:0]);
    st_ = int'(ps[7:4]); so = int'(ps[3:0]);
    ok = ho <= 9 && ht * 10 + ho <= 12 && mt <= 5 && mo <= 9 && st_ <= 5 && so <= 9;
    m_done = 0; m_err = 0;
    if (rs) begin m_rem = 0; m_st = IDLE; end
    else if (ld) begin
      if (ok) begin m_rem = (ht * 10 + ho) * 3600 + (mt * 10 + mo) * 60 + st_ * 10 + so; m_st = IDLE; end
      else m_err = 1;
    end
    else if (sp && m_st == RUN) m_st = PAUSED;
    else if (st && (m_st == IDLE || m_st == PAUSED)) begin if (m_rem != 0) m_st = RUN; end
    else if (tk && m_st == RUN) begin
      m_rem--;
      if (m_rem == 0) begin m_st = EXP; m_done = 1; end
    end
    @(posedge clk); #1;
    chk("hh", bus.hh, bcd(m_rem / 3600));
    chk("mm", bus.mm, bcd((m_rem / 60) % 60));
    chk("ss", bus.ss, bcd(m_rem % 60));
    chk("running", 8'(bus.running), 8'(m_st == RUN));
    chk("expired", 8'(bus.expired), 8'(m_st == EXP));
    chk("done", 8'(bus.done), 8'(m_done));
    chk("load_err", 8'(bus.load_err), 8'(m_err));
  endtask
  task automatic idle(int n, bit tk);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, tk);
  endtask
  task automatic ld(logic [7:0] h, logic [7:0] m, logic [7:0] s);
    step(0, 1, h, m, s, 0, 0, 0);
  endtask
  task automatic go();
    step(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
  endtask
  initial begin
    step(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    idle(1, 0);
    ld(8'h00, 8'h01, 8'h05); go(); idle(66, 1);
    ld(8'h10, 8'h00, 8'h00); go(); idle(1, 1);
    ld(8'h01, 8'h00, 8'h00); go(); idle(1, 1);
    ld(8'h13, 8'h00, 8'h00); idle(1, 0);
    ld(8'h00, 8'h60, 8'h00); idle(1, 0);
    ld(8'h00, 8'h00, 8'h0A); idle(1, 0);
    ld(8'h12, 8'h59, 8'h59); go(); idle(2, 1);
    ld(8'h00, 8'h00, 8'h10); go();
    step(0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    idle(3, 1);
    step(0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 1);
    idle(1, 1);
    ld(8'h00, 8'h00, 8'h00); go(); idle(2, 1);
    ld(8'h00, 8'h02, 8'h00); go(); idle(5, 1);
    step(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    ld(8'h00, 8'h00, 8'h02); go(); idle(4, 1);
    step(0, 1, 8'h00, 8'h00, 8'h03, 0, 0, 1);
    idle(2, 1); go(); idle(4, 1);
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [7:0] ph, pm, ps;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 7) == 0) begin ph = 8'($urandom); pm = 8'($urandom); ps = 8'($urandom); end
      else begin
        ph = ($urandom_range(0, 5) == 0) ? bcd(int'($urandom_range(0, 12))) : 8'h00;
        pm = bcd(int'($urandom_range(0, 1)));
        ps = bcd(int'($urandom_range(0, 59)));
      end
      step(r == 99, r < 3, ph, pm, ps, r >= 3 && r < 12, r >= 12 && r < 16, r[0]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/watch_countdown_timer.md
# watch_countdown_timer

Countdown timer for the watch controller: the decrementing counterpart of the hour/minute/second up-counter chain. It loads a BCD HH:MM:SS preset (hours 0–12), counts down once per 1 Hz tick and borrows across digits. It stops at 00:00:00 and raises a one-cycle `done` pulse plus a level `expired` flag. Its BCD digit outputs use the same 4-bit-per-digit format as the clock counters, so the display mux can select between them.

## Interface
Parameters:
- `HOUR_MAX`, default 12: maximum loadable hour value.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `tick`  in  1  one-cycle 1 Hz enable, synchronous to `clk`.
- `load`  in  1  one-cycle pulse; captures the `preset_*` inputs.
- `preset_h`  in  8  BCD hours {tens, ones}.
- `preset_m`  in  8  BCD minutes {tens, ones}.
- `preset_s`  in  8  BCD seconds {tens, ones}.
- `start_resume`  in  1  level/pulse; starts or resumes counting.
- `stop`  in  1  pauses counting.
- `hh`  out  8  current hours, BCD.
- `mm`  out  8  current minutes, BCD.
- `ss`  out  8  current seconds, BCD.
- `running`  out  1  high in the RUN state.
- `expired`  out  1  high in the EXPIRED state.
- `done`  out  1  one-cycle pulse on reaching zero.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- States are IDLE, RUN, PAUSED and EXPIRED.
- Reset state: IDLE, all digits 0, all outputs 0.
- Per-cycle priority: `reset` > `load` > `stop` > `start_resume` > `tick`.
- **load**
  - Validity: ones digits ≤ 9; `mm`/`ss` tens ≤ 5; hours value ≤ `HOUR_MAX`, meaning hour tens ≤ 1, and hour ones ≤ 2 when tens = 1.
  - Valid load: digits take the preset, state goes to IDLE from any state, and `expired` clears.
  - Invalid load: digits and state are unchanged, and `load_err` pulses.
- **start_resume**
  - IDLE or PAUSED with a nonzero count goes to RUN.
  - A zero count stays in its state.
  - Ignored in RUN and EXPIRED.
- **stop**: RUN goes to PAUSED; ignored elsewhere.
- **tick in RUN**: decrement by one second.
  - Seconds ones: 0 becomes 9 and borrows; otherwise −1.
  - Seconds tens: 0 becomes 5 and borrows.
  - Minutes use the same rule as seconds.
  - Hours are decremented as a BCD value: 10 → 09, 00 never underflows.
  - Example: 10:00:00 → 09:59:59.
- If the decrement produces 00:00:00, the same edge moves to EXPIRED, asserts `expired` and pulses `done`.
- In EXPIRED, ticks are ignored and digits hold at zero. Only a valid `load` or `reset` leaves EXPIRED.
- `tick` outside RUN has no effect.

## Timing
- All outputs are registered.
- A digit change appears on the edge that samples `tick`=1 in RUN, so latency is 1 cycle.
- `done` is high exactly one cycle, the first cycle in which the digits read 00:00:00; it never re-fires in EXPIRED.
- `load_err` is high exactly one cycle, the cycle after the rejected `load`.
- `running` and `expired` follow the state register with no extra delay.
- Simultaneous events:
  - `stop` + `tick` in RUN: pause with no decrement.
  - `load` + `tick`: the load wins and no decrement is applied to the new value.
  - `start_resume` + `tick` from PAUSED: the state becomes RUN and that tick is not counted.
- Reset mid-count: the next edge gives IDLE, 00:00:00 and all flags 0.

## Structure
- Shared package `watch_pkg`:
  - state encoding `TMR_IDLE`/`TMR_RUN`/`TMR_PAUSED`/`TMR_EXPIRED` (2 bits);
  - digit maxima `SEC_TENS_MAX`=5, `DIGIT_MAX`=9, `HOUR_MAX`=12;
  - BCD digit width 4.
- Sub-module `bcd_down_digit`, parameterised by `MAX`:
  - inputs: `load`, `load_val`, `dec_en`;
  - outputs: `digit`, `borrow_out` (asserted when `dec_en` and `digit`==0).
- Digits chain ss-ones → ss-tens → mm-ones → mm-tens. The hours pair has its own wrap logic in the top level.
- FSM, validity check and zero detect live in the top level.

## Test plan
- Reset → all outputs 0 and state IDLE. Then `load` 00:01:05, `start_resume`, 65 ticks → `ss`/`mm` step down, `done` pulses once at 00:00:00, `expired`=1, and a 66th tick leaves 00:00:00.
- Load 10:00:00, RUN, one tick → 09:59:59; load 01:00:00, one tick → 00:59:59.
- Invalid loads 13:00:00, 00:60:00 and 00:00:0A → `load_err` one-cycle pulse each, digits unchanged. Load 12:59:59 → accepted.
- RUN at 00:00:10: `stop`+`tick` in the same cycle → stays 00:00:10, PAUSED. Further ticks have no effect. `start_resume` → RUN, next tick → 00:00:09.
- Load 00:00:00 then `start_resume` → stays IDLE, `running`=0, no `done`.
- Mid-count: `reset` → 00:00:00/IDLE next edge. In EXPIRED, a valid `load` 00:00:03 → IDLE, `expired`=0; `load`+`tick` together → value 00:00:03, no decrement.
